// File: rtl/bit_count_arbiter_pkg.sv
// Shared types and defaults for the round-robin bit-count arbiter.
package bit_count_arbiter_pkg;

    localparam int unsigned DefaultNReq  = 4;
    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StAck
    } state_e;

endpackage

// File: rtl/bit_count_arbiter_if.sv
// Request/acknowledge bundle between the requesters and the arbiter.
interface bit_count_arbiter_if #(
    parameter int unsigned N_REQ = bit_count_arbiter_pkg::DefaultNReq,
    parameter int unsigned WIDTH = bit_count_arbiter_pkg::DefaultWidth
);
    localparam int unsigned IdW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [N_REQ-1:0]            req;
    logic [N_REQ-1:0][WIDTH-1:0] num;
    logic [N_REQ-1:0]            ack;
    logic [CntW-1:0]             result;
    logic                        busy;
    logic [IdW-1:0]              grant_id;

    modport master (output req, output num, input ack, input result, input busy,
                    input grant_id);
    modport slave  (input req, input num, output ack, output result, output busy,
                    output grant_id);
endinterface

// File: rtl/bit_counter.sv
// Serial popcount: captures num while start is low, then shifts one bit per cycle.
module bit_counter #(
    parameter int unsigned WIDTH = bit_count_arbiter_pkg::DefaultWidth,
    localparam int unsigned CntW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] num,
    input  logic             start,
    output logic [CntW-1:0]  result,
    output logic             done
);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CntW-1:0]  step_q, step_d;
    logic             done_q, done_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        done_d  = done_q;
        if (!start) begin
            shift_d = num;
            cnt_d   = '0;
            step_d  = '0;
            done_d  = 1'b0;
        end else if (!done_q) begin
            cnt_d   = cnt_q + CntW'(shift_q[0]);
            shift_d = shift_q >> 1;
            step_d  = step_q + 1'b1;
            // done rises on the edge that consumes the last operand bit
            if (step_q == CntW'(WIDTH - 1)) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            step_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    assign result = cnt_q;
    assign done   = done_q;

endmodule

// File: rtl/bit_count_arbiter.sv
// Round-robin arbiter sharing one serial bit counter among N_REQ requesters.
module bit_count_arbiter
    import bit_count_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = DefaultNReq,
    parameter int unsigned WIDTH = DefaultWidth
) (
    input logic                clk,
    input logic                reset,
    bit_count_arbiter_if.slave bus
);

    localparam int unsigned IdW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [IdW-1:0]   grant_q, grant_d;
    logic [IdW-1:0]   rr_q, rr_d;
    logic [IdW-1:0]   pick;
    logic             found;
    int unsigned      idx;
    logic             cnt_start;
    logic [WIDTH-1:0] cnt_num;
    logic [CntW-1:0]  cnt_result;
    logic             cnt_done;

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .num    (cnt_num),
        .start  (cnt_start),
        .result (cnt_result),
        .done   (cnt_done)
    );

    // First pending request at or after rr_q, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        idx   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (int'(rr_q) + i) % N_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = IdW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        cnt_start  = 1'b0;
        cnt_num    = '0;
        bus.ack    = '0;
        bus.result = '0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = pick;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cnt_num = bus.num[grant_q];
                state_d = StRun;
            end
            StRun: begin
                cnt_start = 1'b1;
                if (cnt_done) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                bus.ack[grant_q] = 1'b1;
                bus.result       = cnt_result;
                rr_d    = (grant_q == IdW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.busy     = (state_q != StIdle);
    assign bus.grant_id = grant_q;

endmodule

// File: tb/tb_bit_count_arbiter.sv
// Directed bench for bit_count_arbiter with a per-cycle protocol monitor.
module tb_bit_count_arbiter;
    import bit_count_arbiter_pkg::*;

    localparam int unsigned NReq  = 4;
    localparam int unsigned Width = 8;

    logic clk;
    logic reset;
    bit   mon_en;
    int   n_checks;
    int   n_fail;
    int   lat;

    bit_count_arbiter_if #(.N_REQ(NReq), .WIDTH(Width)) bus ();

    bit_count_arbiter #(
        .N_REQ (NReq),
        .WIDTH (Width)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for any ack, then checks which requester and what count.
    task automatic wait_ack(input string tag, input int unsigned exp_id,
                            input int unsigned exp_res, input int budget, output int cycles);
        cycles = 0;
        while (bus.ack == '0 && cycles < budget) begin
            tick();
            cycles++;
        end
        if (bus.ack == '0) begin
            check_eq({tag, "_timeout"}, 0, 1);
        end else begin
            check_eq({tag, "_ack"}, 32'(bus.ack), 32'(1) << exp_id);
            check_eq({tag, "_res"}, 32'(bus.result), exp_res);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            check_eq("ack_onehot0", 32'($onehot0(bus.ack)), 1);
            if (bus.ack == '0) check_eq("res_idle_zero", 32'(bus.result), 0);
            check_eq("ack_in_ack_state", 32'(bus.ack != '0), 32'(dut.state_q == StAck));
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        reset    = 1'b1;
        bus.req  = '0;
        bus.num  = '0;
        tick();
        tick();
        mon_en = 1'b1;
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_ack", 32'(bus.ack), 0);
        check_eq("rst_result", 32'(bus.result), 0);
        check_eq("rst_grant", 32'(bus.grant_id), 0);
        reset = 1'b0;
        tick();

        // Single request, two bits set.
        bus.num[0] = 8'b1000_0001;
        bus.req    = 4'b0001;
        tick();
        check_eq("t1_busy", 32'(bus.busy), 1);
        check_eq("t1_grant", 32'(bus.grant_id), 0);
        wait_ack("t1", 0, 2, 12, lat);
        check_eq("t1_latency_ok", 32'(lat + 1 <= 12), 1);
        bus.req = '0;
        tick();
        check_eq("t1_busy_after", 32'(bus.busy), 0);
        check_eq("t1_ack_after", 32'(bus.ack), 0);

        // All four held high: rotation 0,1,2,3,0 from a fresh pointer.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.num[0] = 8'hFF;
        bus.num[1] = 8'h00;
        bus.num[2] = 8'h0F;
        bus.num[3] = 8'h01;
        bus.req    = 4'b1111;
        wait_ack("rr0", 0, 8, 14, lat);
        tick();
        wait_ack("rr1", 1, 0, 14, lat);
        tick();
        wait_ack("rr2", 2, 4, 14, lat);
        tick();
        wait_ack("rr3", 3, 1, 14, lat);
        tick();
        wait_ack("rr4", 0, 8, 14, lat);
        bus.req = '0;
        tick();
        check_eq("rr_idle", 32'(bus.busy), 0);

        // req[2] in service must not be pre-empted by req[0]; pointer wraps to 0.
        bus.num[2] = 8'h33;
        bus.num[0] = 8'h07;
        bus.req    = 4'b0100;
        tick();
        tick();
        tick();
        bus.req = 4'b0101;
        check_eq("np_grant", 32'(bus.grant_id), 2);
        wait_ack("np2", 2, 4, 14, lat);
        bus.req = 4'b0001;
        tick();
        wait_ack("np0", 0, 3, 14, lat);
        bus.req = '0;
        tick();

        // Reset mid-run aborts; a fresh request is then served.
        bus.num[1] = 8'hFF;
        bus.req    = 4'b0010;
        tick();
        tick();
        tick();
        tick();
        reset   = 1'b1;
        bus.req = '0;
        tick();
        reset = 1'b0;
        check_eq("ab_busy", 32'(bus.busy), 0);
        check_eq("ab_ack", 32'(bus.ack), 0);
        check_eq("ab_grant", 32'(bus.grant_id), 0);
        tick();
        check_eq("ab_no_ack", 32'(bus.ack), 0);
        bus.req = 4'b0010;
        wait_ack("ab1", 1, 8, 14, lat);
        bus.req = '0;
        tick();

        // Request withdrawn during run still completes exactly once.
        bus.num[1] = 8'h0F;
        bus.req    = 4'b0010;
        tick();
        tick();
        tick();
        tick();
        bus.req = '0;
        wait_ack("dr1", 1, 4, 14, lat);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("dr_no_ack", 32'(bus.ack), 0);
            check_eq("dr_idle", 32'(bus.busy), 0);
        end

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
